// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the iterative InvMixColumns stage: an input
// valid/ready channel carrying the state plus its bypass flag, and an
// output valid/ready channel carrying the transformed state.
interface inv_mix_columns_seq_if;
    logic         IN_VALID;
    logic         IN_READY;
    logic [127:0] IN_DATA;
    logic         BYPASS;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [127:0] OUT_DATA;

    // Upstream/downstream side: drives the request and consumes the result
    modport master (
        output IN_VALID,
        output IN_DATA,
        output BYPASS,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT_DATA
    );

    // Block side: accepts a state and presents the result
    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  BYPASS,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output OUT_DATA
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES-128 InvMixColumns stage for the decryption datapath.
// A state is accepted into a work register, COLS_PER_CYCLE columns are
// transformed in place per BUSY cycle, and the finished state is held on
// the output until the downstream takes it. With the bypass flag set the
// work register is left untouched, so the final round sees identical latency.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_mix_columns_seq_if.slave bus
);

    // Only 1, 2 and 4 columns per cycle divide the four columns evenly
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols_per_cycle
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter step and the counter value seen on the last BUSY cycle.
    // With four columns per cycle the step truncates to 0 and every BUSY
    // cycle is the last one.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [127:0]   work;
    logic [127:0]   work_next;
    logic [127:0]   out_data;
    logic           out_valid;
    logic [1:0]     cnt;
    logic           bypass_q;
    logic [1:0]     col_idx;

    // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // One column through the inverse circulant matrix; row 0 is the MSB
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Transform the columns addressed by the counter this cycle; column j
    // lives at bit offset 32*(3-j), and 3-j is simply ~j in two bits
    always_comb begin
        work_next = work;
        col_idx   = cnt;
        if (!bypass_q) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                col_idx = cnt + 2'(k);
                work_next[{~col_idx, 5'b0} +: 32] = inv_mix_col(work[{~col_idx, 5'b0} +: 32]);
            end
        end
    end

    // Control FSM with registered result and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cnt       <= 2'd0;
            bypass_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        work     <= bus.IN_DATA;
                        bypass_q <= bus.BYPASS;
                        cnt      <= 2'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    cnt  <= cnt + CNT_STEP;
                    if (cnt == CNT_LAST) begin
                        out_data  <= work_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.OUT_READY) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.IN_READY  = (state == IDLE) && !rst;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Iterative AES-128 InvMixColumns stage for the decryption datapath; the inverse of the encryption MixColumns transform.
- Accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Presents the result over a valid/ready handshake.
- BYPASS passes the state through unchanged with identical latency, for the final decryption round that has no InvMixColumns.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error. N = 4/COLS_PER_CYCLE is the number of BUSY cycles.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
IN_VALID  input  1  IN_DATA and BYPASS are valid.
IN_READY  output  1  block can accept a state.
IN_DATA  input  128  state. Column j = bits [127-32j -: 32]. Row 0 is the most significant byte of each column.
BYPASS  input  1  sampled with IN_DATA. 1 = output equals input.
OUT_VALID  output  1  OUT_DATA holds a completed result.
OUT_READY  input  1  downstream accepts OUT_DATA.
OUT_DATA  output  128  transformed state, same byte layout as IN_DATA.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, OUT_VALID=0, OUT_DATA=0, column counter=0, bypass flag=0.
- IN_READY = (state==IDLE) && !rst. It is 0 while rst is high.
- States:
  - IDLE: on IN_VALID&&IN_READY, latch IN_DATA into the work register, latch BYPASS, clear the counter, go to BUSY.
  - BUSY: each cycle, transform columns counter..counter+COLS_PER_CYCLE-1 in place in the work register (no change if bypass flag=1), then counter += COLS_PER_CYCLE. The 2-bit counter wraps to 0. On the N-th BUSY cycle, load OUT_DATA with the final work value, set OUT_VALID=1, go to DONE.
  - DONE: OUT_VALID=1; OUT_DATA held stable. On OUT_READY=1, OUT_VALID=0 and go to IDLE on that edge. IN_DATA is ignored in DONE.
- Latency: for acceptance at edge k, OUT_VALID rises after edge k+N. N is the same for BYPASS=0 and BYPASS=1.
- Throughput: minimum accept-to-accept spacing is N+2 cycles, achieved with OUT_READY held at 1.
- Column arithmetic, per column (a0..a3 in, b0..b3 out), GF(2^8) with reduction polynomial 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplier construction: xtime(x) = (x<<1) ^ (x[7] ? 1b : 00), truncated to 8 bits. Then:
  - 09·x = x8^x
  - 0b·x = x8^x2^x
  - 0d·x = x8^x4^x
  - 0e·x = x8^x4^x2
  - where x2 = xtime(x), x4 = xtime(x2), x8 = xtime(x4).
- No combinational path from IN_DATA to OUT_DATA. OUT_DATA changes only on the edge that sets OUT_VALID, and on reset.
- IN_VALID while not in IDLE is not accepted. The upstream holds IN_DATA until IN_READY.
- OUT_READY high while OUT_VALID=0 has no effect.
- Reset mid-operation (BUSY or DONE): work and output are discarded. The next cycle is IDLE with OUT_VALID=0 and OUT_DATA=0. IN_READY returns to 1 in the first cycle rst is low.
- Reset asserted in the same cycle as an input or output handshake: reset wins, and the handshake does not occur.

Test Plan:
- FIPS-197 columns, BYPASS=0, COLS_PER_CYCLE=1, OUT_READY=1. IN_DATA=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> OUT_DATA=db135345_f20a225c_01010101_d4d4d4d5. OUT_VALID rises exactly 4 edges after acceptance and stays 1 for one cycle.
- Same vector with COLS_PER_CYCLE=2 and 4 -> identical OUT_DATA, latency 2 and 1 respectively.
- BYPASS=1, IN_DATA=00112233_44556677_8899aabb_ccddeeff -> same value out after N cycles.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_VALID and OUT_DATA stable, IN_READY=0 throughout. Pulse OUT_READY -> OUT_VALID=0 next cycle, IN_READY=1.
- Reset in the 2nd BUSY cycle -> OUT_VALID never rises and OUT_DATA=0. A following new input produces its correct result with normal latency.
- Round trip: random states through the encryption MixColumns then this block (BYPASS=0), 1000 iterations -> output equals original state. Back-to-back inputs with IN_VALID held at 1 -> accept spacing N+2 cycles.
